// File: rtl/imsic_msi_intp_files.sv
// IMSIC-style MSI receive stage.
// Buffers incoming {file, id} MSI writes in a small FIFO and drains one per
// cycle into per-file pending arrays. Each file also gets a registered
// top-interrupt identity (topei) and a registered interrupt request.
//
// MSI port handshake: a write transfers on a rising edge where msi_valid_i
// and msi_ready_o are both high. msi_ready_o depends only on the FIFO fill
// level, so it never depends on msi_valid_i. While the port is ready, the
// source holds msi_file_i/msi_id_i stable whenever msi_valid_i is high.
module imsic_msi_intp_files #(
  parameter int NR_VS_FILES = 1,
  parameter int NR_FILES    = 2 + NR_VS_FILES,
  parameter int FILE_W      = $clog2(NR_FILES),
  parameter int NR_SRC      = 30,
  parameter int SRC_W       = $clog2(NR_SRC),
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         msi_valid_i,
  output logic                         msi_ready_o,
  input  logic [FILE_W-1:0]            msi_file_i,
  input  logic [SRC_W-1:0]             msi_id_i,
  input  logic [NR_FILES*NR_SRC-1:0]   eie_i,
  input  logic [NR_FILES*SRC_W-1:0]    eithreshold_i,
  input  logic [NR_FILES-1:0]          eidelivery_i,
  input  logic                         claim_valid_i,
  input  logic [FILE_W-1:0]            claim_file_i,
  output logic [NR_FILES*NR_SRC-1:0]   eip_o,
  output logic [NR_FILES*SRC_W-1:0]    topei_o,
  output logic [NR_FILES-1:0]          irq_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FILE_W-1:0]          file_mem_q [FIFO_DEPTH];
  logic [FILE_W-1:0]          file_mem_d [FIFO_DEPTH];
  logic [SRC_W-1:0]           id_mem_q   [FIFO_DEPTH];
  logic [SRC_W-1:0]           id_mem_d   [FIFO_DEPTH];
  logic [PTR_W-1:0]           wptr_q, wptr_d;
  logic [PTR_W-1:0]           rptr_q, rptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [NR_FILES*NR_SRC-1:0] eip_q, eip_d;
  logic [NR_FILES*SRC_W-1:0]  topei_q, topei_d;
  logic [NR_FILES-1:0]        irq_q, irq_d;

  logic                       enq, deq;
  logic [FILE_W-1:0]          drain_file;
  logic [SRC_W-1:0]           drain_id;
  logic [NR_FILES-1:0]        unused_eie_bit0;

  // Ready is purely a function of the fill level; a full FIFO refuses the
  // write even if an entry drains on the same edge.
  assign msi_ready_o = (count_q != CNT_W'(FIFO_DEPTH));
  assign enq         = msi_valid_i && msi_ready_o;
  assign deq         = (count_q != '0);
  assign drain_file  = file_mem_q[rptr_q];
  assign drain_id    = id_mem_q[rptr_q];

  assign eip_o   = eip_q;
  assign topei_o = topei_q;
  assign irq_o   = irq_q;

  // FIFO bookkeeping: write at wptr, unconditional drain at rptr.
  always_comb begin
    file_mem_d = file_mem_q;
    id_mem_d   = id_mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (enq) begin
      file_mem_d[wptr_q] = msi_file_i;
      id_mem_d[wptr_q]   = msi_id_i;
      wptr_d             = wptr_q + PTR_W'(1);
    end
    if (deq) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pending update: claim clears the current top, then the drained MSI sets
  // its bit so a same-edge set wins. Loop bounds restrict matches to valid
  // files and identities 1..NR_SRC-1, so anything else is dropped.
  always_comb begin
    eip_d = eip_q;
    for (int f = 0; f < NR_FILES; f++) begin
      for (int i = 1; i < NR_SRC; i++) begin
        if (claim_valid_i && (claim_file_i == FILE_W'(f)) &&
            (topei_q[f*SRC_W +: SRC_W] == SRC_W'(i))) begin
          eip_d[f*NR_SRC + i] = 1'b0;
        end
        if (deq && (drain_file == FILE_W'(f)) && (drain_id == SRC_W'(i))) begin
          eip_d[f*NR_SRC + i] = 1'b1;
        end
      end
    end
  end

  // Top identity per file: lowest enabled pending id below the threshold.
  always_comb begin
    logic [SRC_W-1:0] thr;
    logic [SRC_W-1:0] cand;
    topei_d         = '0;
    irq_d           = '0;
    unused_eie_bit0 = '0;
    thr             = '0;
    cand            = '0;
    for (int f = 0; f < NR_FILES; f++) begin
      thr  = eithreshold_i[f*SRC_W +: SRC_W];
      cand = '0;
      for (int i = NR_SRC - 1; i >= 1; i--) begin
        if (eip_q[f*NR_SRC + i] && eie_i[f*NR_SRC + i] &&
            ((thr == '0) || (SRC_W'(i) < thr))) begin
          cand = SRC_W'(i);
        end
      end
      topei_d[f*SRC_W +: SRC_W] = cand;
      irq_d[f]                  = eidelivery_i[f] && (cand != '0);
      unused_eie_bit0[f]        = eie_i[f*NR_SRC];
    end
  end

  // FIFO storage needs no reset: entries are only read once counted.
  always_ff @(posedge clk_i) begin
    file_mem_q <= file_mem_d;
    id_mem_q   <= id_mem_d;
  end

  // Control and output state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      eip_q   <= '0;
      topei_q <= '0;
      irq_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      eip_q   <= eip_d;
      topei_q <= topei_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_imsic_msi_intp_files.sv
// Bench for imsic_msi_intp_files: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the MSI file.
module tb_imsic_msi_intp_files;

  localparam int NR_FILES   = 3;
  localparam int FILE_W     = 2;
  localparam int NR_SRC     = 30;
  localparam int SRC_W      = 5;
  localparam int FIFO_DEPTH = 4;

  // clock / reset and DUT inputs
  logic clk = 1'b0;
  logic rst;
  logic msi_valid;
  logic [FILE_W-1:0] msi_file;
  logic [SRC_W-1:0] msi_id;
  logic [NR_FILES*NR_SRC-1:0] eie;
  logic [NR_FILES*SRC_W-1:0] thr;
  logic [NR_FILES-1:0] deliv;
  logic claim_valid;
  logic [FILE_W-1:0] claim_file;
  logic msi_ready;
  logic [NR_FILES*NR_SRC-1:0] eip;
  logic [NR_FILES*SRC_W-1:0] topei;
  logic [NR_FILES-1:0] irq;

  always #5 clk = ~clk;

  imsic_msi_intp_files dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .msi_valid_i   (msi_valid),
    .msi_ready_o   (msi_ready),
    .msi_file_i    (msi_file),
    .msi_id_i      (msi_id),
    .eie_i         (eie),
    .eithreshold_i (thr),
    .eidelivery_i  (deliv),
    .claim_valid_i (claim_valid),
    .claim_file_i  (claim_file),
    .eip_o         (eip),
    .topei_o       (topei),
    .irq_o         (irq)
  );

  // scoreboard / reference model
  logic [FILE_W+SRC_W-1:0] exp_q[$];
  bit eip_m [NR_FILES][NR_SRC];
  int top_m [NR_FILES];
  bit irq_m [NR_FILES];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int thr_of(int f);
    return int'(thr[f*SRC_W +: SRC_W]);
  endfunction

  // Lowest enabled pending identity that passes the threshold rule.
  function automatic int ref_top(int f);
    for (int i = 1; i < NR_SRC; i++) begin
      if (eip_m[f][i] && eie[f*NR_SRC+i] && (thr_of(f) == 0 || i < thr_of(f)))
        return i;
    end
    return 0;
  endfunction

  function automatic logic [NR_FILES*NR_SRC-1:0] eip_flat();
    logic [NR_FILES*NR_SRC-1:0] v = '0;
    for (int f = 0; f < NR_FILES; f++)
      for (int i = 0; i < NR_SRC; i++) v[f*NR_SRC+i] = eip_m[f][i];
    return v;
  endfunction

  function automatic logic [SRC_W-1:0] dut_top(int f);
    return topei[f*SRC_W +: SRC_W];
  endfunction

  // Advance the model by one clock edge using the inputs present at it.
  task automatic model_step();
    int nt [NR_FILES];
    bit can_enq;
    logic [FILE_W+SRC_W-1:0] e;
    int ef, ei, cf;
    if (rst) begin
      exp_q.delete();
      for (int f = 0; f < NR_FILES; f++) begin
        for (int i = 0; i < NR_SRC; i++) eip_m[f][i] = 0;
        top_m[f] = 0;
        irq_m[f] = 0;
      end
      return;
    end
    for (int f = 0; f < NR_FILES; f++) nt[f] = ref_top(f);
    can_enq = msi_valid && (exp_q.size() != FIFO_DEPTH);
    cf = int'(claim_file);
    if (claim_valid && cf < NR_FILES && top_m[cf] != 0) eip_m[cf][top_m[cf]] = 0;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      ef = int'(e[SRC_W +: FILE_W]);
      ei = int'(e[SRC_W-1:0]);
      if (ef < NR_FILES && ei >= 1 && ei < NR_SRC) eip_m[ef][ei] = 1;
    end
    if (can_enq) exp_q.push_back({msi_file, msi_id});
    for (int f = 0; f < NR_FILES; f++) begin
      top_m[f] = nt[f];
      irq_m[f] = deliv[f] && (nt[f] != 0);
    end
  endtask

  task automatic check_all();
    logic [NR_FILES*SRC_W-1:0] et = '0;
    logic [NR_FILES-1:0] ei = '0;
    for (int f = 0; f < NR_FILES; f++) begin
      et[f*SRC_W +: SRC_W] = SRC_W'(top_m[f]);
      ei[f] = irq_m[f];
    end
    chk("ready", 128'(msi_ready), 128'(exp_q.size() != FIFO_DEPTH));
    chk("eip", 128'(eip), 128'(eip_flat()));
    chk("topei", 128'(topei), 128'(et));
    chk("irq", 128'(irq), 128'(ei));
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input int f, input int id);
    msi_valid = 1'b1;
    msi_file  = FILE_W'(f);
    msi_id    = SRC_W'(id);
    tick();
    msi_valid = 1'b0;
  endtask

  task automatic claim(input int f);
    claim_valid = 1'b1;
    claim_file  = FILE_W'(f);
    tick();
    claim_valid = 1'b0;
  endtask

  logic [NR_FILES*NR_SRC-1:0] snap;

  initial begin
    rst = 1'b1; msi_valid = 1'b0; msi_file = '0; msi_id = '0;
    eie = '1; thr = '0; deliv = '1; claim_valid = 1'b0; claim_file = '0;
    do_reset();
    chk("rst_eip", 128'(eip), 128'(0));
    chk("rst_ready", 128'(msi_ready), 128'(1));

    // single MSI: bit at N+1, topei/irq at N+2
    send(1, 7);
    tick();
    chk("single_eip", 128'(eip[1*NR_SRC+7]), 128'(1));
    tick();
    chk("single_top", 128'(dut_top(1)), 128'(7));
    chk("single_irq", 128'(irq), 128'(3'b010));

    // priority and threshold
    do_reset();
    send(0, 12); send(0, 5); send(0, 20);
    idle(2);
    chk("prio_top", 128'(dut_top(0)), 128'(5));
    thr[0 +: SRC_W] = 5'd5;
    tick();
    chk("thr5_top", 128'(dut_top(0)), 128'(0));
    chk("thr5_irq", 128'(irq[0]), 128'(0));
    thr[0 +: SRC_W] = 5'd13;
    tick();
    chk("thr13_top", 128'(dut_top(0)), 128'(5));
    thr = '0;

    // claim sequence
    do_reset();
    send(0, 5); send(0, 12);
    idle(2);
    claim(0);
    tick();
    chk("claim1_top", 128'(dut_top(0)), 128'(12));
    claim(0);
    tick();
    chk("claim2_top", 128'(dut_top(0)), 128'(0));
    chk("claim2_eip", 128'(eip[NR_SRC-1:0]), 128'(0));
    claim(3);

    // claim/set collision on file 2 id 3
    do_reset();
    send(2, 3);
    idle(2);
    chk("coll_pre", 128'(dut_top(2)), 128'(3));
    send(2, 3);
    claim_valid = 1'b1; claim_file = 2'd2;
    tick();
    claim_valid = 1'b0;
    chk("coll_eip", 128'(eip[2*NR_SRC+3]), 128'(1));
    tick();
    chk("coll_top", 128'(dut_top(2)), 128'(3));

    // invalid writes are accepted and dropped
    snap = eip_flat();
    send(0, 0); send(0, 30); send(3, 5);
    idle(2);
    chk("inval_eip", 128'(eip), 128'(snap));

    // back-to-back burst, then reset mid-burst
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      chk("burst_ready", 128'(msi_ready), 128'(1));
      send(1, k);
    end
    idle(2);
    chk("burst_eip", 128'(eip[1*NR_SRC +: NR_SRC]), 128'(30'h1FE));
    chk("burst_top", 128'(dut_top(1)), 128'(1));
    send(1, 9); send(1, 10);
    msi_valid = 1'b1; msi_id = 5'd11; rst = 1'b1;
    tick();
    rst = 1'b0; msi_valid = 1'b0;
    chk("midrst_eip", 128'(eip), 128'(0));
    chk("midrst_top", 128'(topei), 128'(0));
    idle(3);
    chk("midrst_lost", 128'(eip), 128'(0));

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      if (c % 16 == 0) begin
        eie   = {$urandom, $urandom, $urandom};
        thr   = NR_FILES*SRC_W'($urandom);
        deliv = NR_FILES'($urandom);
        if ($urandom_range(0, 1) == 0) thr = '0;
      end
      rst         = ($urandom_range(0, 99) == 0);
      msi_valid   = ($urandom_range(0, 3) != 0);
      msi_file    = FILE_W'($urandom_range(0, 3));
      msi_id      = SRC_W'($urandom_range(0, 31));
      claim_valid = ($urandom_range(0, 3) == 0);
      claim_file  = FILE_W'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b0; msi_valid = 1'b0; claim_valid = 1'b0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
